// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph codes (common with the encoder), bit
// positions and the scan-decoder state type.
package seg_pkg;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;
    localparam logic [7:0] SEG_E = 8'h79;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_B_BIT  = 1;
    localparam int SEG_C_BIT  = 2;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 4;
    localparam int SEG_F_BIT  = 5;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 7-segment glyph to BCD decode; anything that is not a
// digit glyph (including the E glyph) yields 4'hF with err set.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_err
);

    always_comb begin
        o_nibble = 4'hF;
        o_err    = 1'b1;
        case (i_pattern)
            SEG_0[6:0]: begin o_nibble = 4'd0; o_err = 1'b0; end
            SEG_1[6:0]: begin o_nibble = 4'd1; o_err = 1'b0; end
            SEG_2[6:0]: begin o_nibble = 4'd2; o_err = 1'b0; end
            SEG_3[6:0]: begin o_nibble = 4'd3; o_err = 1'b0; end
            SEG_4[6:0]: begin o_nibble = 4'd4; o_err = 1'b0; end
            SEG_5[6:0]: begin o_nibble = 4'd5; o_err = 1'b0; end
            SEG_6[6:0]: begin o_nibble = 4'd6; o_err = 1'b0; end
            SEG_7[6:0]: begin o_nibble = 4'd7; o_err = 1'b0; end
            SEG_8[6:0]: begin o_nibble = 4'd8; o_err = 1'b0; end
            SEG_9[6:0]: begin o_nibble = 4'd9; o_err = 1'b0; end
            default: begin
                o_nibble = 4'hF;
                o_err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/segment_scan_decoder.sv
// Readback of a multiplexed 4-digit 7-segment bus: waits for each digit to
// settle, captures it into a shadow slot and publishes once all four are in.
module segment_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_seg,
    input  logic [3:0]  i_dig_sel,
    output logic [15:0] o_bcd,
    output logic [3:0]  o_dp,
    output logic [3:0]  o_err,
    output logic        o_valid
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(SETTLE_CYCLES);

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [CW-1:0]   w_cnt_inc;
    logic [11:0]     r_prev;
    logic [11:0]     w_cur;
    logic            w_same;
    logic            w_onehot;
    logic            w_commit;
    logic            w_publish;
    logic [3:0]      r_mask;
    logic [3:0]      w_mask_merged;
    logic [3:0]      w_nib;
    logic            w_glyph_err;
    logic [3:0]      r_shadow_nib [4];
    logic [3:0]      r_shadow_dp;
    logic [3:0]      r_shadow_err;
    logic [15:0]     w_frame_bcd;
    logic [3:0]      w_frame_dp;
    logic [3:0]      w_frame_err;

    seg_glyph_decode u_glyph (
        .i_pattern (i_seg[6:0]),
        .o_nibble  (w_nib),
        .o_err     (w_glyph_err)
    );

    assign w_cur     = {i_seg, i_dig_sel};
    assign w_same    = (w_cur == r_prev);
    assign w_onehot  = is_onehot4(i_dig_sel);
    assign w_cnt_inc = (r_cnt == CNT_TARGET) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prev  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_prev  <= w_cur;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_onehot)
                    w_state_next = SETTLE;
            end
            SETTLE: begin
                if (!w_onehot)
                    w_state_next = IDLE;
                else if (w_same && (w_cnt_inc == CNT_TARGET))
                    w_state_next = HOLD;
            end
            HOLD: begin
                if (!w_same)
                    w_state_next = w_onehot ? SETTLE : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A change on the commit cycle restarts the count instead of committing.
    always_comb begin
        w_cnt_next = '0;
        w_commit   = 1'b0;
        case (r_state)
            SETTLE: begin
                if (w_onehot && w_same) begin
                    w_cnt_next = w_cnt_inc;
                    w_commit   = (w_cnt_inc == CNT_TARGET);
                end
            end
            HOLD: begin
                if (w_same)
                    w_cnt_next = r_cnt;
            end
            default: w_cnt_next = '0;
        endcase
    end

    assign w_mask_merged = r_mask | i_dig_sel;
    assign w_publish     = w_commit && (w_mask_merged == 4'hF);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_shadow_nib[gi] <= 4'd0;
                    r_shadow_dp[gi]  <= 1'b0;
                    r_shadow_err[gi] <= 1'b0;
                end else if (w_commit && i_dig_sel[gi]) begin
                    r_shadow_nib[gi] <= w_nib;
                    r_shadow_dp[gi]  <= i_seg[SEG_DP_BIT];
                    r_shadow_err[gi] <= w_glyph_err;
                end
            end

            // Bypass so the publishing commit includes the digit just sampled.
            assign w_frame_bcd[4*gi +: 4] = (w_commit && i_dig_sel[gi]) ? w_nib : r_shadow_nib[gi];
            assign w_frame_dp[gi]  = (w_commit && i_dig_sel[gi]) ? i_seg[SEG_DP_BIT] : r_shadow_dp[gi];
            assign w_frame_err[gi] = (w_commit && i_dig_sel[gi]) ? w_glyph_err : r_shadow_err[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask  <= 4'd0;
            o_bcd   <= 16'd0;
            o_dp    <= 4'd0;
            o_err   <= 4'd0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= w_publish;
            if (w_publish) begin
                r_mask <= 4'd0;
                o_bcd  <= w_frame_bcd;
                o_dp   <= w_frame_dp;
                o_err  <= w_frame_err;
            end else if (w_commit) begin
                r_mask <= w_mask_merged;
            end
        end
    end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Self-checking bench for segment_scan_decoder: directed scenarios plus
// random dwells, compared every cycle against a dwell-length model.
module tb_segment_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic [15:0] o_bcd;
    logic [3:0]  o_dp;
    logic [3:0]  o_err;
    logic        o_valid;

    always #5 clk = ~clk;

    segment_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_seg     (seg),
        .i_dig_sel (sel),
        .o_bcd     (o_bcd),
        .o_dp      (o_dp),
        .o_err     (o_err),
        .o_valid   (o_valid)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a dwell commits on its (S+1)-th identical cycle.
    logic [6:0]  glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [11:0] m_prev;
    bit          m_have = 0;
    int          m_len = 0;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_dp, m_err, m_mask;
    logic [15:0] e_bcd;
    logic [3:0]  e_dp, e_err;
    logic        e_valid;
    bit          started = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_have = 0; m_len = 0; m_mask = 0; m_dp = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_nib[i] = 0;
            e_bcd = 0; e_dp = 0; e_err = 0; e_valid = 0;
        end else begin
            if (m_have && ({seg, sel} == m_prev)) begin
                if (m_len < 1000) m_len++;
            end else begin
                m_len = 1;
            end
            m_prev = {seg, sel};
            m_have = 1;
            e_valid = 0;
            if ($countones(sel) == 1 && m_len == S + 1) begin
                int idx;
                logic [3:0] nib;
                logic er;
                idx = 0;
                for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
                nib = 4'hF; er = 1'b1;
                for (int d = 0; d < 10; d++)
                    if (glyph_tab[d] == seg[6:0]) begin nib = 4'(d); er = 1'b0; end
                m_nib[idx] = nib;
                m_dp[idx]  = seg[7];
                m_err[idx] = er;
                m_mask[idx] = 1'b1;
                if (m_mask == 4'hF) begin
                    e_bcd = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    e_dp = m_dp; e_err = m_err; e_valid = 1;
                    m_mask = 0;
                end
            end
        end
    end

    int          pub_cnt = 0;
    logic [15:0] last_bcd;
    logic [3:0]  last_dp, last_err;

    always @(negedge clk) begin
        if (started) begin
            check("bcd",   o_bcd,   e_bcd);
            check("dp",    16'(o_dp),  16'(e_dp));
            check("err",   16'(o_err), 16'(e_err));
            check("valid", 16'(o_valid), 16'(e_valid));
            if (o_valid === 1'b1) begin
                pub_cnt++;
                last_bcd = o_bcd; last_dp = o_dp; last_err = o_err;
            end
        end
    end

    task automatic dwell(input logic [3:0] s, input logic [7:0] g, input int n);
        sel = s; seg = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int p0;

    initial begin
        rst = 1; seg = 0; sel = 0;
        @(posedge clk); #1;
        started = 1;
        repeat (2) @(posedge clk); #1;
        rst = 0;
        check("rst_bcd", o_bcd, 16'h0);
        check("rst_valid", 16'(o_valid), 16'h0);

        // Full frame 1234, with exact publish-cycle pinning on digit 4
        p0 = pub_cnt;
        dwell(4'b0001, 8'h66, 8);
        dwell(4'b0010, 8'h4F, 8);
        dwell(4'b0100, 8'h5B, 8);
        dwell(4'b1000, 8'h06, 4);
        check("f1_before_pub", 16'(o_valid), 16'h0);
        dwell(4'b1000, 8'h06, 1);
        check("f1_pub_valid", 16'(o_valid), 16'h1);
        check("f1_pub_bcd", o_bcd, 16'h1234);
        dwell(4'b1000, 8'h06, 3);
        dwell(4'b0000, 8'h00, 4);
        check("f1_pubs", 16'(pub_cnt - p0), 16'd1);
        check("f1_bcd", last_bcd, 16'h1234);
        check("f1_dp", 16'(last_dp), 16'h0);
        check("f1_err", 16'(last_err), 16'h0);

        // Glitch rejection: a 3-cycle dwell is too short
        p0 = pub_cnt;
        dwell(4'b0001, 8'h7D, 3);
        dwell(4'b0010, 8'h6D, 8);
        dwell(4'b0100, 8'h07, 8);
        dwell(4'b1000, 8'h7F, 8);
        check("gl_nopub", 16'(pub_cnt - p0), 16'd0);
        dwell(4'b0001, 8'h7D, 8);
        dwell(4'b0000, 8'h00, 4);
        check("gl_pubs", 16'(pub_cnt - p0), 16'd1);
        check("gl_bcd", last_bcd, 16'h8756);

        // Error glyph and decimal point
        p0 = pub_cnt;
        dwell(4'b0001, 8'h6F, 8);
        dwell(4'b0010, 8'h79, 8);
        dwell(4'b0100, 8'hBF, 8);
        dwell(4'b1000, 8'h3F, 8);
        dwell(4'b0000, 8'h00, 4);
        check("ed_pubs", 16'(pub_cnt - p0), 16'd1);
        check("ed_bcd", last_bcd, 16'h00F9);
        check("ed_err", 16'(last_err), 16'h0002);
        check("ed_dp", 16'(last_dp), 16'h0004);

        // Illegal selects must not commit nor disturb the mask
        p0 = pub_cnt;
        dwell(4'b0001, 8'h06, 8);
        dwell(4'b0010, 8'h5B, 8);
        dwell(4'b0011, 8'h06, 20);
        dwell(4'b0000, 8'h00, 20);
        check("il_nopub", 16'(pub_cnt - p0), 16'd0);
        dwell(4'b0100, 8'h4F, 8);
        dwell(4'b1000, 8'h66, 8);
        dwell(4'b0000, 8'h00, 4);
        check("il_pubs", 16'(pub_cnt - p0), 16'd1);
        check("il_bcd", last_bcd, 16'h4321);

        // Repeat capture of digit 1 overwrites
        p0 = pub_cnt;
        dwell(4'b0001, 8'h6D, 8);
        dwell(4'b0001, 8'h07, 8);
        dwell(4'b0010, 8'h3F, 8);
        dwell(4'b0100, 8'h3F, 8);
        dwell(4'b1000, 8'h3F, 8);
        dwell(4'b0000, 8'h00, 4);
        check("rp_pubs", 16'(pub_cnt - p0), 16'd1);
        check("rp_bcd", last_bcd, 16'h0007);

        // Reset mid-frame discards partial captures
        p0 = pub_cnt;
        dwell(4'b0001, 8'h06, 8);
        dwell(4'b0010, 8'h06, 8);
        dwell(4'b0100, 8'h06, 8);
        sel = 0; seg = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        dwell(4'b1000, 8'h06, 8);
        dwell(4'b0000, 8'h00, 4);
        check("rs_pubs", 16'(pub_cnt - p0), 16'd0);
        check("rs_bcd", o_bcd, 16'h0);
        check("rs_dp", 16'(o_dp), 16'h0);
        check("rs_err", 16'(o_err), 16'h0);

        // Random dwells, checked cycle by cycle against the model
        for (int k = 0; k < 300; k++) begin
            int r;
            logic [3:0] s;
            logic [7:0] g;
            r = $urandom_range(0, 9);
            if (r == 0) s = 4'b0000;
            else if (r == 1) s = 4'b0011 << $urandom_range(0, 2);
            else s = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) g = {1'($urandom_range(0, 1)), glyph_tab[$urandom_range(0, 9)]};
            else g = 8'($urandom);
            if ($urandom_range(0, 80) == 0) begin
                rst = 1;
                @(posedge clk); #1;
                rst = 0;
            end
            dwell(s, g, $urandom_range(1, 9));
        end
        dwell(4'b0000, 8'h00, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
